mem_ctrl: RTL

- Request-side controller directly upstream of the single-port `memory` block (ports clk/wr/rd/addr/data, bidirectional data bus).
- Accepts write/read requests over a valid/ready handshake and sequences `memory`'s wr/rd/addr strobes.
- Owns the tri-state data bus and returns read data over a valid/ready response channel.
- Replaces hand-driven strobes so downstream logic never touches the shared bus directly.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl request-side memory controller.
// The optional MEM_CTRL_STATS_EN counters use STATS_W and sat_inc.
package mem_ctrl_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    RD_ISSUE   = 2'd2,
    RD_CAPTURE = 2'd3
  } mem_state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Request-side controller for the single-port memory: sequences wr/rd/addr strobes,
// owns the tri-state data bus, returns read data. Optional macro: MEM_CTRL_STATS_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] wr_count,
  output logic [STATS_W-1:0] rd_count
`endif
);

  mem_state_e        state_q;
  mem_state_e        state_d;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              bus_drive;
  logic              accept;

  // Handshakes: a beat transfers on a posedge where valid && ready are both 1.
  // The producer holds its payload stable while valid=1 and ready=0; ready never
  // depends on valid, so there is no combinational loop across either channel.
  assign req_ready = (state_q == IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = req_wr ? WRITE : RD_ISSUE;
      WRITE:      state_d = IDLE;
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    bus_drive = 1'b0;
    case (state_q)
      WRITE: begin
        mem_wr    = 1'b1;
        bus_drive = 1'b1;
      end
      RD_ISSUE, RD_CAPTURE: mem_rd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign mem_addr = addr_q;
  // Only WRITE drives the bus, so a write->read turnaround always has a released cycle.
  assign mem_data = bus_drive ? wdata_q : {DWIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else if (state_q == RD_CAPTURE) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= mem_data;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MEM_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (state_q == WRITE)      wr_count <= sat_inc(wr_count);
      if (state_q == RD_CAPTURE) rd_count <= sat_inc(rd_count);
    end
  end
`endif

endmodule
